// File: rtl/addsub_seq_pkg.sv
// Shared constants for the nibble-serial add/subtract unit.
//   ST_*  : controller state encodings (IDLE, RUN, DONE)
//   OP_*  : operation select encodings carried on the op port
package addsub_seq_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_rca.sv
// 4-bit ripple-carry adder slice.
//   a, b   : nibble operands
//   c_in   : carry into bit 0
//   sum    : nibble sum
//   c_out  : carry out of bit 3
module rca (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    always_comb begin
        {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle WIDTH-bit add/subtract controller using one 4-bit adder slice.
// Operands are captured on an accepted start, then one nibble is summed per
// clock from LSB to MSB, with the inter-nibble carry held in a register.
//   clk, rst         : rising-edge clock, synchronous active-high reset
//   start, op, a, b  : request (accepted only while ready), 0=add 1=sub
//   ready            : high only in IDLE
//   done             : one-cycle pulse, result and flags valid
//   result           : sum/difference, held until the next operation runs
//   c_out, ovf, zero : final carry (sub: 1 = no borrow), signed overflow, result==0
module addsub_seq
    import addsub_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
        $error("addsub_seq: WIDTH must be a multiple of 4 and at least 4");
    end

    logic [1:0]       state_q,  state_d;
    logic [IDXW-1:0]  idx_q,    idx_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             c_out_q,  c_out_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;

    logic [3:0] slice_a, slice_b, slice_sum;
    logic       slice_co;

    // b is stored pre-inverted for subtract; the +1 comes from the initial carry.
    assign slice_a = a_q[{idx_q, 2'b00} +: 4];
    assign slice_b = b_q[{idx_q, 2'b00} +: 4];

    rca u_rca (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_co)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = (op == OP_SUB) ? ~b : b;
                    carry_d = op;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[{idx_q, 2'b00} +: 4] = slice_sum;
                carry_d = slice_co;
                idx_d   = idx_q + 1'b1;
                if (idx_q == IDXW'(NIB - 1)) begin
                    c_out_d = slice_co;
                    // Operand signs agree but the result sign differs.
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
                    zero_d  = (result_d == '0);
                    idx_d   = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign c_out  = c_out_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: doc/addsub_seq.md
Name: addsub_seq

Overview:
Multi-cycle WIDTH-bit add/subtract controller built around a single 4-bit ripple-carry adder slice.
- Latches operands on a start handshake, then steps the slice across one nibble per clock from LSB to MSB, carrying between nibbles in a register.
- Reports the result, carry-out, signed overflow and zero with a one-cycle done pulse.
- Serves as the area-cheap arithmetic unit for wide operands in the datapath.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; otherwise elaboration error.
- NIB, WIDTH/4, number of nibble steps (derived localparam, not overridable).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- op  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; result/flags valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- c_out  output  1  final carry; for subtract, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst=1 on an edge, any state):
  - state=IDLE, ready=1, done=0.
  - result=0, c_out=0, ovf=0, zero=0.
  - nibble index=0, carry reg=0.
  - Reset mid-operation abandons the operation; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On an edge with start=1:
    - latch a_r=a.
    - latch b_r = op ? ~b : b.
    - latch op_r.
    - carry = op.
    - idx = 0.
    - go to RUN.
  - start=0 stays in IDLE.
- RUN:
  - ready=0.
  - The slice computes a_r[4*idx+3:4*idx] + b_r[4*idx+3:4*idx] + carry.
  - Each edge writes the sum nibble into result[4*idx+3:4*idx], loads carry with the slice c_out and increments idx.
  - On the edge where idx==NIB-1, additionally:
    - c_out = slice c_out.
    - ovf = (a_r[WIDTH-1]==b_r[WIDTH-1]) && (sum MSB != a_r[WIDTH-1]).
    - zero = (full new result == 0).
    - go to DONE.
  - Exactly NIB edges are spent in RUN.
- DONE:
  - done=1 for exactly one cycle.
  - ready=0.
  - Next edge goes to IDLE.
- Latency: start accepted at edge E0; done is high during the cycle following edge E0+NIB. With WIDTH=16, done is high after the 4th RUN edge. A new start is accepted no earlier than 2 edges after done rises (DONE then IDLE).
- start while ready=0 is ignored. It is not queued and does not disturb the operation.
- Input changes to a, b or op after acceptance have no effect.
- result, c_out, ovf and zero update during RUN and are valid only when done=1. They hold their last values in IDLE until the next operation's RUN edges overwrite them.
- All arithmetic is modulo 2^WIDTH; no saturation.
- Subtract is implemented as a + ~b + 1.
- The idx counter width is clog2(NIB), minimum 1.

Decomposition:
- Shared package contents:
  - state encoding constants ST_IDLE, ST_RUN, ST_DONE.
  - op encoding constants OP_ADD=0, OP_SUB=1.
- Sub-module: one instance of the team's existing 4-bit ripple-carry adder `rca`, ports a, b, c_in, sum, c_out. Its nibble inputs are selected by idx from a_r/b_r.
- All control logic (FSM, idx counter, carry register, result register) lives in addsub_seq.

Test Plan (WIDTH=16):
1. Add: start, op=0, a=0x1234, b=0x4321 -> done 5 cycles after the accept edge, result=0x5555, c_out=0, ovf=0, zero=0; ready=1 the cycle after done.
2. Add wrap: a=0xFFFF, b=0x0001 -> result=0x0000, c_out=1, ovf=0, zero=1.
3. Sub with borrow: op=1, a=0x0005, b=0x0007 -> result=0xFFFE, c_out=0, ovf=0. Sub 0x8000-0x0001 -> result=0x7FFF, c_out=1, ovf=1.
4. Signed overflow add: a=0x7FFF, b=0x0001 -> result=0x8000, ovf=1, c_out=0.
5. Busy start: accept 0x00F0+0x0010, then pulse start with a=0xAAAA in RUN cycle 2 -> ignored. Exactly one done; result=0x0100; no second done.
6. Reset mid-op: accept 0x1111+0x2222, assert rst in RUN cycle 2 -> next cycle state IDLE, ready=1, result=0, done never pulses. A subsequent op 0x0001+0x0001 gives 0x0002.
